id_stage: RTL

Pipelined instruction-decode stage of the MIPS image-processing core, between instruction fetch and execute. It latches one fetched instruction and splits it into register indices and the raw 16-bit immediate, which feeds the sign extender. It also generates the control bundle and holds the instruction while a load-use hazard is pending. Fetch and execute connect through valid/ready handshakes.

---
 rtl/mips_pkg.sv | 27 ++
 rtl/id_control_decoder.sv | 61 ++++++
 rtl/id_stage.sv | 76 +++++++
 3 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: opcodes, ALU-op encodings and the decode control bundle
package mips_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_LOGIC = 2'b11;
  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic       reg_dst;
    logic       branch;
    logic       jump;
    logic       zext;
    logic [1:0] alu_op;
  } ctrl_t;
endpackage

// File: rtl/id_control_decoder.sv
// id_control_decoder: opcode to control bundle; ID_ZERO_EXT_EN enables zext and xori
module id_control_decoder
  import mips_pkg::*;
(
  input  logic [5:0] opcode_i,
  output ctrl_t      ctrl_o,
  output logic       illegal_o
);
`ifdef ID_ZERO_EXT_EN
  localparam logic ZEXT_EN = 1'b1;
`else
  localparam logic ZEXT_EN = 1'b0;
`endif
  // opcode lookup; unknown opcodes give an all-zero bundle and flag illegal
  always_comb begin
    ctrl_o    = '0;
    illegal_o = 1'b0;
    case (opcode_i)
      OP_RTYPE: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = 1'b1;
        ctrl_o.alu_op    = ALU_FUNCT;
      end
      OP_ADDI: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.alu_op    = ALU_ADD;
      end
      OP_ANDI, OP_ORI: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.zext      = ZEXT_EN;
        ctrl_o.alu_op    = ALU_LOGIC;
      end
      OP_XORI: begin
        ctrl_o.reg_write = ZEXT_EN;
        ctrl_o.alu_src   = ZEXT_EN;
        ctrl_o.zext      = ZEXT_EN;
        ctrl_o.alu_op    = ZEXT_EN ? ALU_LOGIC : ALU_ADD;
        illegal_o        = !ZEXT_EN;
      end
      OP_LW: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.alu_op    = ALU_ADD;
      end
      OP_SW: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.alu_op    = ALU_ADD;
      end
      OP_BEQ: begin
        ctrl_o.branch = 1'b1;
        ctrl_o.alu_op = ALU_SUB;
      end
      OP_J: ctrl_o.jump = 1'b1;
      default: illegal_o = 1'b1;
    endcase
  end
endmodule

// File: rtl/id_stage.sv
// id_stage: decode pipeline stage with valid/ready handshake and load-use stall; ID_ZERO_EXT_EN selects zero-extend decode
module id_stage
  import mips_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   if_valid,
  input  logic [31:0]            if_instr,
  input  logic [ADDR_W-1:0]      if_pc,
  output logic                   if_ready,
  input  logic                   flush,
  input  logic                   ex_ready,
  input  logic                   ex_mem_read,
  input  logic [4:0]             ex_rt,
  output logic                   id_valid,
  output logic [ADDR_W-1:0]      id_pc,
  output logic [4:0]             id_rs,
  output logic [4:0]             id_rt,
  output logic [4:0]             id_rd,
  output logic [15:0]            id_imm16,
  output logic [25:0]            id_jaddr,
  output logic [9:0]             id_ctrl,
  output logic                   id_illegal,
  output logic [STALL_CNT_W-1:0] stall_cnt
);
  logic                   full_q, full_d;
  logic [31:0]            instr_q, instr_d;
  logic [ADDR_W-1:0]      pc_q, pc_d;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;
  ctrl_t                  ctrl;
  logic                   illegal, hazard, accept, drain;
  id_control_decoder u_dec (
    .opcode_i (instr_q[31:26]),
    .ctrl_o   (ctrl),
    .illegal_o(illegal)
  );
  assign hazard     = full_q && ex_mem_read && (ex_rt != 5'd0) &&
                      (ex_rt == instr_q[25:21] || ex_rt == instr_q[20:16]);
  assign id_valid   = full_q && !hazard && !flush;
  assign if_ready   = !flush && (!full_q || (id_valid && ex_ready));
  assign accept     = if_valid && if_ready;
  assign drain      = id_valid && ex_ready;
  assign id_pc      = pc_q;
  assign id_rs      = instr_q[25:21];
  assign id_rt      = instr_q[20:16];
  assign id_rd      = instr_q[15:11];
  assign id_imm16   = instr_q[15:0];
  assign id_jaddr   = instr_q[25:0];
  assign id_ctrl    = full_q ? ctrl : '0;
  assign id_illegal = full_q && illegal;
  assign stall_cnt  = stall_q;
  // flush beats accept, accept beats drain; stall counter saturates
  always_comb begin
    full_d  = flush ? 1'b0 : accept ? 1'b1 : drain ? 1'b0 : full_q;
    instr_d = accept ? if_instr : instr_q;
    pc_d    = accept ? if_pc : pc_q;
    stall_d = (hazard && stall_q != '1) ? stall_q + 1'b1 : stall_q;
  end
  // stage register, emptied asynchronously by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q  <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
      stall_q <= '0;
    end else begin
      full_q  <= full_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      stall_q <= stall_d;
    end
  end
endmodule
